reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Upstream controller for the target-reset pulse generator. Accepts a reset request from the
//  command layer and emits a one-cycle enable to the pulse generator. It then watches the
//  generator's active-low output fall and rise. After that it waits a runtime boot delay and
//  reports target_ready, so a glitch campaign can re-arm on a freshly booted target.
// PARAMETERS
//  TIMEOUT_CYCLES  24'd25_000_000  max cycles from FIRE until the pulse output returns high; else error
//  HOLDOFF_CYCLES  16'd1_000       mandatory idle gap after each sequence before a new req is accepted
// PORTS
//  clk             in   1   system clock, all logic on rising edge
//  rst             in   1   asynchronous, active-high reset
//  req             in   1   level request to run one reset sequence; sampled only in IDLE
//  boot_wait       in   24  post-release wait in cycles; latched when req is accepted
//  ack             out  1   one-cycle strobe: sequence finished (success or timeout)
//  busy            out  1   high in every state except IDLE
//  rst_enable      out  1   one-cycle pulse to the pulse generator's enable input
//  rst_active_low  in   1   pulse generator output (low = target held in reset)
//  target_ready    out  1   high from DONE until the next accepted req
//  timeout_err     out  1   sticky; set on timeout, cleared when the next req is accepted
//  seq_count       out  16  successful sequences completed; wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (async, rst=1):
//   - state=IDLE.
//   - ack, busy, rst_enable, target_ready, timeout_err = 0; seq_count=0; all counters 0.
//   - rst asserted mid-sequence aborts immediately; no ack is issued.
//  All outputs are registered.
//  States: IDLE, FIRE, WAIT_LOW, WAIT_HIGH, BOOT, DONE, HOLDOFF.
//  - IDLE: if req=1 at edge n, latch boot_wait into bw_q; target_ready<=0; timeout_err<=0;
//    go to FIRE. rst_enable=1 during cycle n+1 only. busy=1 from n+1.
//  - FIRE (1 cycle): clear tmo counter; go to WAIT_LOW.
//  - WAIT_LOW: wait for rst_active_low=0, then go to WAIT_HIGH. tmo counter increments each cycle.
//  - WAIT_HIGH: wait for rst_active_low=1, then clear the BOOT counter and go to BOOT.
//    tmo continues counting; it is not cleared between WAIT_LOW and WAIT_HIGH.
//  - Timeout: in WAIT_LOW or WAIT_HIGH, when tmo reaches TIMEOUT_CYCLES-1:
//    - timeout_err<=1; ack<=1 for one cycle; target_ready stays 0; seq_count unchanged;
//    - go to HOLDOFF.
//    - If the awaited edge and the terminal count occur in the same cycle, the edge wins.
//  - BOOT: count 0..bw_q-1, then go to DONE. If bw_q=0, go to DONE on the next cycle.
//    A change on boot_wait during the sequence has no effect.
//  - BOOT: if rst_active_low falls again (external re-trigger), return to WAIT_HIGH and keep tmo.
//  - DONE (1 cycle): ack<=1, target_ready<=1, seq_count<=seq_count+1; go to HOLDOFF.
//  - HOLDOFF: count HOLDOFF_CYCLES cycles, then go to IDLE (busy=0).
//    If HOLDOFF_CYCLES=0, go to IDLE the next cycle.
//  Handshake:
//   - req is ignored (not queued) while busy=1.
//   - The requester drops req after ack; a req still high when IDLE is re-entered starts a new
//     sequence. Back-to-back sequences are spaced by at least HOLDOFF_CYCLES+1.
//  ack and rst_enable are never high in the same cycle. rst_enable is never high outside FIRE.
// TESTING
//  (bench: pulse generator instantiated with PULSE_CYCLES=20; TIMEOUT_CYCLES=100; HOLDOFF_CYCLES=5)
//  1. req=1, boot_wait=10 -> rst_enable 1 cycle after accept; rst_active_low low ~21 cycles;
//     ack 10 cycles after release; target_ready=1; seq_count=1.
//  2. boot_wait=0 -> DONE one cycle after BOOT entry; ack asserted; target_ready=1.
//  3. rst_active_low forced low by the bench -> timeout_err=1 and ack at FIRE+100 cycles;
//     target_ready=0; seq_count unchanged.
//  4. req held high continuously -> sequences repeat; accept-to-accept gap includes 5 holdoff cycles;
//     req pulses while busy are ignored.
//  5. rst asserted in BOOT -> all outputs 0 asynchronously; next req runs a clean sequence.
//  6. seq_count preloaded near 16'hFFFF via 2 runs from force -> wraps to 0;
//     timeout_err from a prior run clears on the next accept.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: drives one pulse-generator enable per request, tracks the
// active-low reset pulse, waits a boot delay and reports the target ready.
// Ports:
//   clk, rst        rising-edge clock, async active-high reset
//   req             level request, sampled only while idle
//   boot_wait       post-release wait in cycles, latched on accept
//   ack             one-cycle strobe when a sequence ends (ok or timeout)
//   busy            high whenever the sequencer is not idle
//   rst_enable      one-cycle enable to the pulse generator
//   rst_active_low  pulse generator output, low holds the target in reset
//   target_ready    high from a successful finish until the next accept
//   timeout_err     sticky timeout flag, cleared on the next accept
//   seq_count       successful sequences, wraps at 16 bits
module reset_sequencer #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd25_000_000,
    parameter logic [15:0] HOLDOFF_CYCLES = 16'd1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [23:0] boot_wait,
    output logic        ack,
    output logic        busy,
    output logic        rst_enable,
    input  logic        rst_active_low,
    output logic        target_ready,
    output logic        timeout_err,
    output logic [15:0] seq_count
);

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_LOW,
        WAIT_HIGH,
        BOOT,
        DONE,
        HOLDOFF
    } state_t;

    state_t      state;
    logic [23:0] bw_q;
    logic [23:0] tmo;
    logic [23:0] bcnt;
    logic [15:0] hcnt;

    logic tmo_end;
    logic boot_end;
    logic hold_end;

    // ">=" because leaving WAIT_LOW on the terminal count still
    // advances tmo, so WAIT_HIGH must time out on the following edge.
    assign tmo_end  = (tmo >= TIMEOUT_CYCLES - 24'd1);
    assign boot_end = (bw_q == 24'd0) || (bcnt == bw_q - 24'd1);
    assign hold_end = (HOLDOFF_CYCLES == 16'd0) ||
                      (hcnt == HOLDOFF_CYCLES - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bw_q         <= '0;
            tmo          <= '0;
            bcnt         <= '0;
            hcnt         <= '0;
            ack          <= 1'b0;
            busy         <= 1'b0;
            rst_enable   <= 1'b0;
            target_ready <= 1'b0;
            timeout_err  <= 1'b0;
            seq_count    <= '0;
        end else begin
            ack        <= 1'b0;
            rst_enable <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        bw_q         <= boot_wait;
                        target_ready <= 1'b0;
                        timeout_err  <= 1'b0;
                        rst_enable   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= FIRE;
                    end
                end
                FIRE: begin
                    tmo   <= '0;
                    state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // The awaited edge takes priority over the timeout.
                    if (!rst_active_low) begin
                        tmo   <= tmo + 24'd1;
                        state <= WAIT_HIGH;
                    end else if (tmo_end) begin
                        timeout_err <= 1'b1;
                        ack         <= 1'b1;
                        hcnt        <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rst_active_low) begin
                        bcnt  <= '0;
                        state <= BOOT;
                    end else if (tmo_end) begin
                        timeout_err <= 1'b1;
                        ack         <= 1'b1;
                        hcnt        <= '0;
                        state       <= HOLDOFF;
                    end else begin
                        tmo <= tmo + 24'd1;
                    end
                end
                BOOT: begin
                    // A new fall means the generator re-fired; tmo is kept.
                    if (!rst_active_low) begin
                        state <= WAIT_HIGH;
                    end else if (boot_end) begin
                        ack          <= 1'b1;
                        target_ready <= 1'b1;
                        seq_count    <= seq_count + 16'd1;
                        state        <= DONE;
                    end else begin
                        bcnt <= bcnt + 24'd1;
                    end
                end
                DONE: begin
                    hcnt  <= '0;
                    state <= HOLDOFF;
                end
                HOLDOFF: begin
                    if (hold_end) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hcnt <= hcnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized sequences against an edge-timing model of
// the sequencer, with a behavioural pulse generator and a forced-line mode.
module tb_reset_sequencer;

    localparam int T     = 100;
    localparam int H     = 5;
    localparam int PULSE = 20;
    localparam int BIG   = 100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [23:0] boot_wait = '0;
    logic        ack;
    logic        busy;
    logic        rst_enable;
    logic        rst_active_low;
    logic        target_ready;
    logic        timeout_err;
    logic [15:0] seq_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int pg_left = 0;
    logic force_mode = 1'b0;
    logic f_low = 1'b0;
    int p_f1 = BIG;
    int p_r1 = BIG;
    int p_f2 = 0;
    int p_r2 = 0;
    int rel_k = 0;
    int acc_cyc = 0;
    int en_cnt = 0;
    int ack_cnt = 0;
    int viol = 0;
    logic en_prev = 1'b0;
    int exp_acc = 0;
    logic [15:0] exp_cnt = '0;
    bit prev_hold = 1'b0;
    int last_idle = 0;

    reset_sequencer #(
        .TIMEOUT_CYCLES(24'd100),
        .HOLDOFF_CYCLES(16'd5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .boot_wait(boot_wait),
        .ack(ack),
        .busy(busy),
        .rst_enable(rst_enable),
        .rst_active_low(rst_active_low),
        .target_ready(target_ready),
        .timeout_err(timeout_err),
        .seq_count(seq_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse generator: holds its output low PULSE cycles per enable.
    always @(posedge clk) begin
        if (rst_enable) pg_left <= PULSE;
        else if (pg_left > 0) pg_left <= pg_left - 1;
    end

    // Forced line: low on edges [f1,r1) and [f2,r2) after the accept edge.
    always @(posedge clk) begin
        #2;
        rel_k = cyc + 1 - acc_cyc;
        f_low = ((rel_k >= p_f1) && (rel_k < p_r1)) ||
                ((rel_k >= p_f2) && (rel_k < p_r2));
    end

    assign rst_active_low = force_mode ? ~f_low : (pg_left == 0);

    always @(posedge clk) begin
        #1;
        if (ack && rst_enable) viol++;
        if (rst_enable && en_prev) viol++;
        if (rst_enable && !en_prev) begin
            en_cnt++;
            acc_cyc = cyc;
        end
        if (ack) ack_cnt++;
        en_prev = rst_enable;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge offsets relative to the accept edge: the line must be back high
    // within T edges after FIRE, then boot lasts max(bw,1) edges; a fall
    // inside the boot window restarts the wait for the second rise.
    function automatic void predict(input int bw, input int f1,
                                    input int r1, input int f2,
                                    input int r2, output bit tm,
                                    output int rel);
        int b;
        b = (bw < 1) ? 1 : bw;
        if (f1 > T + 1 || r1 > T + 1) begin
            tm  = 1'b1;
            rel = T + 1;
        end else if (f2 > r1 && f2 <= r1 + b && r2 > f2) begin
            tm  = 1'b0;
            rel = r2 + b;
        end else begin
            tm  = 1'b0;
            rel = r1 + b;
        end
    endfunction

    task automatic run(input int bw, input int f1, input int r1,
                       input int f2, input int r2, input bit gen,
                       input bit hold);
        int a;
        int e;
        int d;
        int rel;
        bit tm;
        bit seen;
        p_f1 = f1;
        p_r1 = r1;
        p_f2 = f2;
        p_r2 = r2;
        force_mode = !gen;
        predict(bw, f1, r1, f2, r2, tm, rel);
        @(negedge clk);
        req = 1'b1;
        boot_wait = 24'(bw);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = rst_enable;
        end
        a = cyc;
        chk("accept", 32'(seen), 1);
        if (prev_hold) chk("rearm_gap", a - last_idle, 1);
        chk("busy_fire", 32'(busy), 1);
        chk("ready_err_clr", 32'({target_ready, timeout_err}), 0);
        exp_acc++;
        e = -1;
        for (int i = 0; i < 400 && e < 0; i++) begin
            @(negedge clk);
            if (!hold) begin
                req = 1'($urandom_range(0, 1));
                boot_wait = 24'($urandom);
            end
            @(posedge clk);
            #1;
            if (ack) e = cyc;
        end
        if (!hold) req = 1'b0;
        if (e < 0) begin
            chk("ack_seen", 0, 1);
            prev_hold = 1'b0;
            return;
        end
        chk("ack_latency", e - a, rel);
        if (!tm) exp_cnt++;
        chk("busy_at_ack", 32'(busy), 1);
        chk("ready_at_ack", 32'(target_ready), 32'(!tm));
        chk("err_at_ack", 32'(timeout_err), 32'(tm));
        chk("count_at_ack", 32'(seq_count), 32'(exp_cnt));
        chk("no_en_at_ack", 32'(rst_enable), 0);
        @(posedge clk);
        #1;
        chk("ack_width", 32'(ack), 0);
        d = -1;
        for (int i = 0; i < 40 && d < 0; i++) begin
            if (!busy) d = cyc;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (d < 0) begin
            chk("idle_seen", 0, 1);
            prev_hold = 1'b0;
            return;
        end
        chk("holdoff_len", d - e, tm ? H : H + 1);
        chk("ready_hold", 32'(target_ready), 32'(!tm));
        last_idle = d;
        prev_hold = hold;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int k;
        bit seen;
        @(posedge clk);
        #1;
        chk("reset_flags",
            32'({ack, busy, rst_enable, target_ready, timeout_err}), 0);
        chk("reset_count", 32'(seq_count), 0);
        @(negedge clk);
        rst = 1'b0;

        run(10, 2, 2 + PULSE, 0, 0, 1'b1, 1'b0);
        run(0, 2, 2 + PULSE, 0, 0, 1'b1, 1'b0);
        run(5, 2, BIG, 0, 0, 1'b0, 1'b0);
        run(5, BIG, BIG, 0, 0, 1'b0, 1'b0);
        run(3, 2, T + 1, 0, 0, 1'b0, 1'b0);
        run(3, 2, T + 2, 0, 0, 1'b0, 1'b0);
        run(8, 2, 10, 13, 30, 1'b0, 1'b0);

        for (int j = 0; j < 4; j++) begin
            run(int'($urandom_range(0, 15)), 2, 2 + PULSE, 0, 0,
                1'b1, j < 3);
        end

        // Abort in the middle of the boot wait.
        force_mode = 1'b0;
        @(negedge clk);
        req = 1'b1;
        boot_wait = 24'd20;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = rst_enable;
        end
        a = cyc;
        chk("abort_accept", 32'(seen), 1);
        exp_acc++;
        @(negedge clk);
        req = 1'b0;
        while (cyc < a + 27) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort_flags",
            32'({ack, busy, rst_enable, target_ready, timeout_err}), 0);
        chk("abort_count", 32'(seq_count), 0);
        k = ack_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_cnt = '0;
        prev_hold = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_ack", ack_cnt - k, 0);
        run(4, 2, 2 + PULSE, 0, 0, 1'b1, 1'b0);

        // Timeout, then preload the counter and wrap it.
        run(2, 2, BIG, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        force dut.seq_count = 16'hFFFE;
        @(negedge clk);
        release dut.seq_count;
        #1;
        exp_cnt = 16'hFFFE;
        chk("preload", 32'(seq_count), 32'(exp_cnt));
        run(1, 2, 2 + PULSE, 0, 0, 1'b1, 1'b0);
        run(7, 2, 2 + PULSE, 0, 0, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("enable_count", en_cnt, exp_acc);
        chk("overlap_viol", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
